// File: rtl/uart_pkg.sv
// Shared definitions for the UART core.
// Contents:
//   rx_state_e    - receive FSM states
//   tx_state_e    - transmit FSM states
//   clks_per_bit  - clk cycles per serial bit (integer division)
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter shared by the receive and transmit paths.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, clears the count
//   load_i     - load load_val_i into the counter this cycle
//   load_val_i - value to load; terminal count is reached load_val_i+1 edges later
//   tc_o       - high while the count is zero (stays high until the next load)
module uart_bit_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: one receiver and one transmitter, each with its own bit timer.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   rx       - asynchronous serial input, idle high
//   rx_valid - one-cycle pulse when a byte has been received
//   rx_data  - last received byte, stable between rx_valid pulses
//   tx_data  - byte to transmit, sampled with tx_start
//   tx_start - transmit request strobe, ignored while tx_busy
//   tx       - serial output, idle high
//   tx_busy  - high for the 10 bit times of a transmit frame
//
// RX states:
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | waiting half a bit, then confirming the start bit is still low
//   RX_DATA  | sampling 8 data bits at mid-bit, LSB first
//   RX_STOP  | sampling the stop bit; on framing error, waiting for the line to go high
//
// TX states:
//   state    | meaning
//   TX_IDLE  | line high, accepting tx_start
//   TX_START | driving the start bit
//   TX_DATA  | driving 8 data bits, LSB first
//   TX_STOP  | driving the stop bit
module uart_core
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx,
    output logic       tx_busy
);

    localparam int CPB = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int TW  = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [TW-1:0] FULL_LOAD = TW'(CPB - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'((CPB / 2) - 1);

    // ---------------- receive path ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic            rx_fall;
    rx_state_e       rx_state_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q, rx_data_q;
    logic            rx_valid_q, rx_ferr_q;
    logic            rx_load, rx_tc;
    logic [TW-1:0]   rx_load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    // Timer loads must land on the same edge as the state change they belong to.
    always_comb begin
        rx_load     = 1'b0;
        rx_load_val = FULL_LOAD;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_load     = 1'b1;
                    rx_load_val = HALF_LOAD;
                end
            end
            RX_START: rx_load = rx_tc & ~rx_sync_q;
            RX_DATA:  rx_load = rx_tc;
            default:  rx_load = 1'b0;
        endcase
    end

    uart_bit_timer #(.W(TW)) u_rx_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (rx_load),
        .load_val_i (rx_load_val),
        .tc_o       (rx_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (rx_tc) begin
                        if (rx_sync_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_bit_q   <= 3'd0;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tc) begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // The timer rests at zero after the stop sample, so tc stays
                    // high; the error flag keeps a late-rising line from being
                    // mistaken for a good stop bit.
                    if (rx_tc) begin
                        if (rx_ferr_q) begin
                            if (rx_sync_q) begin
                                rx_ferr_q  <= 1'b0;
                                rx_state_q <= RX_IDLE;
                            end
                        end else if (rx_sync_q) begin
                            rx_data_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_ferr_q <= 1'b1;
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

    // ---------------- transmit path ----------------
    tx_state_e       tx_state_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_shift_q;
    logic            tx_q, tx_busy_q;
    logic            tx_load, tx_tc;

    always_comb begin
        tx_load = 1'b0;
        case (tx_state_q)
            TX_IDLE:  tx_load = tx_start;
            TX_START: tx_load = tx_tc;
            TX_DATA:  tx_load = tx_tc;
            default:  tx_load = 1'b0;
        endcase
    end

    uart_bit_timer #(.W(TW)) u_tx_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tx_load),
        .load_val_i (FULL_LOAD),
        .tc_o       (tx_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_shift_q <= tx_data;
                        tx_q       <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_tc) begin
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        tx_bit_q   <= 3'd0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_tc) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_tc) begin
                        tx_busy_q  <= 1'b0;
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_core.sv
module tb_uart_core;

    localparam int CLOCK_FREQ = 50_000_000;
    localparam int BAUD_RATE  = 115200;
    localparam int CPB        = CLOCK_FREQ / BAUD_RATE;   // 434
    localparam int FRAME      = 10 * CPB;                 // 4340
    // rx_valid is expected about 9.5 bit times after the start bit is driven
    localparam int RXLAT_MIN  = (19 * CPB) / 2 - 10;
    localparam int RXLAT_MAX  = (19 * CPB) / 2 + 17;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] tx_data_drv  = 8'h00;
    logic       tx_start_drv = 1'b0;
    logic       loop_en      = 1'b0;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_start_w;
    logic [7:0] tx_data_w;

    assign tx_start_w = loop_en ? rx_valid : tx_start_drv;
    assign tx_data_w  = loop_en ? rx_data  : tx_data_drv;

    uart_core #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_data  (tx_data_w),
        .tx_start (tx_start_w),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    bit         m_act    = 1'b0;
    int         m_s      = 0;
    logic [7:0] m_byte   = 8'h00;
    logic [7:0] m_last   = 8'h00;
    bit         echo_req = 1'b0;
    exp_t       rxq[$];
    int         valid_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=[%0d..%0d] cyc=%0d", name, val, lo, hi, cyc);
        end
    endtask

    // TX model: a frame accepted at edge s occupies cycles s .. s+FRAME-1.
    bit         p_req;
    logic [7:0] p_dat;
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_act    = 1'b0;
            m_last   = 8'h00;
            echo_req = 1'b0;
            rxq.delete();
        end else begin
            p_req = loop_en ? echo_req : tx_start_drv;
            p_dat = loop_en ? m_last : tx_data_drv;
            if (p_req && !(m_act && (cyc - 1 - m_s) < FRAME)) begin
                m_act  = 1'b1;
                m_s    = cyc;
                m_byte = p_dat;
            end
            echo_req = 1'b0;
        end
    end

    int   c_off, c_j, c_lat;
    logic c_busy, c_tx;
    exp_t c_e;
    initial forever begin
        @(negedge clk);
        if (cyc >= 1) begin
            c_off  = cyc - m_s;
            c_busy = m_act && (c_off >= 0) && (c_off < FRAME);
            c_j    = c_off / CPB;
            if (!c_busy)      c_tx = 1'b1;
            else if (c_j == 0) c_tx = 1'b0;
            else if (c_j <= 8) c_tx = m_byte[3'(c_j - 1)];
            else              c_tx = 1'b1;
            chk("tx_line", 32'(tx), 32'(c_tx));
            chk("tx_busy", 32'(tx_busy), 32'(c_busy));

            if (rx_valid === 1'b1) begin
                valid_cnt++;
                checks++;
                if (rxq.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected actual=valid data=%0h required=no_pulse cyc=%0d", rx_data, cyc);
                end else begin
                    c_e = rxq.pop_front();
                    chk("rx_byte", 32'(rx_data), 32'(c_e.b));
                    c_lat = cyc - c_e.t;
                    chk_range("rx_latency", c_lat, RXLAT_MIN, RXLAT_MAX);
                    m_last   = c_e.b;
                    echo_req = 1'b1;
                end
            end else if (rxq.size() > 0 && (cyc - rxq[0].t) > RXLAT_MAX) begin
                c_e = rxq.pop_front();
                checks++;
                errors++;
                $display("FAIL rx_missing actual=no_pulse required=%0h cyc=%0d", c_e.b, cyc);
            end
            chk("rx_data_hold", 32'(rx_data), 32'(m_last));
        end
    end

    // Drives the first nbits of a frame; a complete good frame is queued as expected.
    task automatic send_frame(input logic [7:0] data_b, input logic stop_bit, input int nbits);
        logic [9:0] f;
        f = {stop_bit, data_b, 1'b0};
        @(negedge clk);
        if (nbits == 10 && stop_bit) rxq.push_back('{b: data_b, t: cyc});
        for (int j = 0; j < nbits; j++) begin
            rx = f[j];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_busy(input string name, input logic level, input int limit);
        int n;
        n = 0;
        while (tx_busy !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_busy !== level) begin
            errors++;
            $display("FAIL %s actual=tx_busy_%0b required=tx_busy_%0b (timeout) cyc=%0d", name, tx_busy, level, cyc);
        end
    endtask

    int         v0, b0, t0, gap, n, cnt;
    logic [9:0] echo_seq;
    logic [7:0] rb;
    bit         ferr;

    initial begin
        echo_seq = 10'b1101001010;   // line order 0,1,0,1,0,0,1,0,1,1 for 0xA5

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // receive 0xA5 and echo it through loopback
        loop_en = 1'b1;
        v0 = valid_cnt;
        fork
            send_frame(8'hA5, 1'b1, 10);
            begin
                wait_busy("echo_start", 1'b1, 2 * FRAME);
                b0 = cyc;
                for (int j = 0; j < 10; j++) begin
                    while (cyc < b0 + j * CPB + CPB / 2) @(negedge clk);
                    chk("echo_bit", 32'(tx), 32'(echo_seq[j]));
                end
                wait_busy("echo_end", 1'b0, FRAME + 10);
                chk("echo_busy_len", cyc - b0, FRAME);
                chk("echo_idle_tx", 32'(tx), 32'd1);
            end
        join
        chk("a5_pulses", valid_cnt - v0, 1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        loop_en = 1'b0;
        repeat (20) @(negedge clk);

        // framing error on 0x3C, then a good 0x5A
        v0 = valid_cnt;
        send_frame(8'h3C, 1'b0, 10);
        repeat (CPB) @(negedge clk);
        chk("ferr_no_valid", valid_cnt - v0, 0);
        chk("ferr_data_kept", 32'(rx_data), 32'hA5);
        send_frame(8'h5A, 1'b1, 10);
        chk("after_ferr_pulses", valid_cnt - v0, 1);
        chk("after_ferr_data", 32'(rx_data), 32'h5A);
        repeat (20) @(negedge clk);

        // 100-cycle glitch, then back-to-back 0x00/0xFF while TX is held requesting
        v0 = valid_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch_no_valid", valid_cnt - v0, 0);
        fork
            begin
                send_frame(8'h00, 1'b1, 10);
                send_frame(8'hFF, 1'b1, 10);
            end
            begin
                tx_data_drv  = 8'h33;
                tx_start_drv = 1'b1;
                wait_busy("hold_start", 1'b1, 100);
                wait_busy("hold_fall", 1'b0, FRAME + 10);
                gap = 0;
                while (tx_busy !== 1'b1 && gap < 10) begin
                    @(negedge clk);
                    gap++;
                end
                chk("b2b_tx_gap", gap, 1);
                tx_start_drv = 1'b0;
                wait_busy("hold_end", 1'b0, FRAME + 10);
            end
        join
        chk("b2b_pulses", valid_cnt - v0, 2);
        chk("b2b_last", 32'(rx_data), 32'hFF);
        repeat (20) @(negedge clk);

        // 0x55 request, 0xAA request 1000 cycles later must be ignored
        @(negedge clk);
        t0 = cyc;
        tx_data_drv  = 8'h55;
        tx_start_drv = 1'b1;
        @(negedge clk);
        tx_start_drv = 1'b0;
        while (cyc < t0 + 1000) @(negedge clk);
        tx_data_drv  = 8'hAA;
        tx_start_drv = 1'b1;
        @(negedge clk);
        tx_start_drv = 1'b0;
        wait_busy("t55_end", 1'b0, FRAME);
        chk("t55_busy_drop", cyc - t0, FRAME + 1);
        cnt = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (tx_busy === 1'b1) cnt++;
        end
        chk("aa_ignored", cnt, 0);

        // reset in the middle of an RX frame and a TX frame
        @(negedge clk);
        tx_data_drv  = 8'hC3;
        tx_start_drv = 1'b1;
        @(negedge clk);
        tx_start_drv = 1'b0;
        send_frame(8'h81, 1'b1, 4);
        chk("mid_tx_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", 32'(tx), 32'd1);
        chk("rst_mid_busy", 32'(tx_busy), 32'd0);
        chk("rst_mid_valid", 32'(rx_valid), 32'd0);
        chk("rst_mid_rx_data", 32'(rx_data), 32'h00);
        rst = 1'b0;
        v0 = valid_cnt;
        repeat (FRAME) @(negedge clk);
        chk("post_rst_pulses", valid_cnt - v0, 0);
        chk("post_rst_tx", 32'(tx), 32'd1);

        // randomized full-duplex traffic
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    rb   = 8'($urandom);
                    ferr = ($urandom_range(0, 4) == 0);
                    send_frame(rb, !ferr, 10);
                    if (ferr) repeat (CPB + $urandom_range(0, 200)) @(negedge clk);
                    else      repeat ($urandom_range(0, 200)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(1, 3000)) @(negedge clk);
                    tx_data_drv  = 8'($urandom);
                    tx_start_drv = 1'b1;
                    @(negedge clk);
                    tx_start_drv = 1'b0;
                end
            end
        join
        wait_busy("drain_tx", 1'b0, FRAME + 10);
        n = 0;
        while (rxq.size() > 0 && n < FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("drain_rxq", rxq.size(), 0);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
